// File: rtl/alarm_ctrl.sv
// Alarm stage: stores a BCD alarm time, compares it with the running clock, rings with snooze.
// Latency: RING/BUZZ assert one CP cycle after the matching TICK; loads land on the next edge.
// Backpressure: none; strobes are single-cycle and always consumed on the edge they are seen.
//
// Ports:
//   CP, nCR            clock (rising edge) and synchronous active-low reset
//   TICK               1 Hz strobe, one CP cycle wide; the only thing that advances time
//   Q_H/Q_M/Q_S        running time, BCD
//   SET, D_H, D_M      alarm load strobe and BCD alarm time to load
//   ALM_EN             arm switch (level); low forces IDLE
//   STOP, SNZ          user strobes; STOP wins when both are high
//   A_H/A_M            stored alarm time, BCD (preset source while setting the alarm)
//   RING, BUZZ, STATE  ringing flag, 1 Hz buzzer drive, state (00 IDLE, 01 RING, 10 SNOOZE)
module alarm_ctrl #(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned MAX_SNOOZE = 3,
  parameter logic [7:0]  RST_H      = 8'h07,
  parameter logic [7:0]  RST_M      = 8'h00
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       TICK,
  input  logic [7:0] Q_H,
  input  logic [7:0] Q_M,
  input  logic [7:0] Q_S,
  input  logic       SET,
  input  logic [7:0] D_H,
  input  logic [7:0] D_M,
  input  logic       ALM_EN,
  input  logic       STOP,
  input  logic       SNZ,
  output logic [7:0] A_H,
  output logic [7:0] A_M,
  output logic       RING,
  output logic       BUZZ,
  output logic [1:0] STATE
);

  localparam int unsigned CNT_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned SNZ_W   = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RING   = 2'b01,
    S_SNOOZE = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         a_h_q, a_h_d;
  logic [7:0]         a_m_q, a_m_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SNZ_W-1:0]   snz_q, snz_d;
  logic               phase_q, phase_d;

  logic load_ok;
  logic match;

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Out-of-range loads are dropped entirely so the stored alarm is always a legal time.
  assign load_ok = SET && bcd_ok(D_H) && bcd_ok(D_M) && (D_H <= 8'h23) && (D_M <= 8'h59);

  // Compares against the registered alarm, so a same-edge SET cannot affect this match.
  assign match = TICK && ALM_EN && (state_q == S_IDLE) &&
                 (Q_H == a_h_q) && (Q_M == a_m_q) && (Q_S == 8'h00);

  always_comb begin
    state_d = state_q;
    a_h_d   = a_h_q;
    a_m_d   = a_m_q;
    cnt_d   = cnt_q;
    snz_d   = snz_q;
    phase_d = phase_q;

    if (load_ok) begin
      a_h_d = D_H;
      a_m_d = D_M;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        phase_d = 1'b0;
        if (match) begin
          state_d = S_RING;
          cnt_d   = CNT_W'(RING_SEC);
          snz_d   = '0;
          phase_d = 1'b1;
        end
      end

      S_RING: begin
        if (!ALM_EN || STOP) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          phase_d = 1'b0;
        end else if (SNZ) begin
          if (snz_q < SNZ_W'(MAX_SNOOZE)) begin
            state_d = S_SNOOZE;
            cnt_d   = CNT_W'(SNOOZE_SEC);
            snz_d   = snz_q + 1'b1;
            phase_d = 1'b0;
          end else begin
            // Snoozes exhausted: the press behaves as STOP.
            state_d = S_IDLE;
            cnt_d   = '0;
            phase_d = 1'b0;
          end
        end else if (TICK) begin
          // <= 1 rather than == 1 also catches a zero count, so it can never wrap.
          if (cnt_q <= CNT_W'(1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            phase_d = 1'b0;
          end else begin
            cnt_d   = cnt_q - 1'b1;
            phase_d = ~phase_q;
          end
        end
      end

      S_SNOOZE: begin
        if (!ALM_EN || STOP) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          phase_d = 1'b0;
        end else if (TICK) begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = S_RING;
            cnt_d   = CNT_W'(RING_SEC);
            phase_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      default: begin
        // Encoding 11 is never produced; recover to IDLE if it ever appears.
        state_d = S_IDLE;
        cnt_d   = '0;
        phase_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CP) begin
    if (!nCR) begin
      state_q <= S_IDLE;
      a_h_q   <= RST_H;
      a_m_q   <= RST_M;
      cnt_q   <= '0;
      snz_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_h_q   <= a_h_d;
      a_m_q   <= a_m_d;
      cnt_q   <= cnt_d;
      snz_q   <= snz_d;
      phase_q <= phase_d;
    end
  end

  assign A_H   = a_h_q;
  assign A_M   = a_m_q;
  assign STATE = state_q;
  assign RING  = (state_q == S_RING);
  assign BUZZ  = (state_q == S_RING) && phase_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: load/validation, ring duration and buzzer phase, snooze limit,
// priority of ALM_EN/STOP/SNZ, SET/match interaction and reset out of SNOOZE.
module tb_alarm_ctrl;

  localparam int RING_SEC   = 60;
  localparam int SNOOZE_SEC = 300;
  localparam int MAX_SNOOZE = 3;

  logic       CP = 1'b0;
  logic       nCR, TICK, SET, ALM_EN, STOP, SNZ;
  logic [7:0] Q_H, Q_M, Q_S, D_H, D_M;
  logic [7:0] A_H, A_M;
  logic       RING, BUZZ;
  logic [1:0] STATE;

  int nchk = 0;
  int nerr = 0;

  alarm_ctrl #(
    .RING_SEC(RING_SEC), .SNOOZE_SEC(SNOOZE_SEC), .MAX_SNOOZE(MAX_SNOOZE),
    .RST_H(8'h07), .RST_M(8'h00)
  ) dut (
    .CP(CP), .nCR(nCR), .TICK(TICK), .Q_H(Q_H), .Q_M(Q_M), .Q_S(Q_S),
    .SET(SET), .D_H(D_H), .D_M(D_M), .ALM_EN(ALM_EN), .STOP(STOP), .SNZ(SNZ),
    .A_H(A_H), .A_M(A_M), .RING(RING), .BUZZ(BUZZ), .STATE(STATE)
  );

  always #5 CP = ~CP;

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic clk1();
    @(posedge CP);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    TICK = 1'b1;
    clk1();
    TICK = 1'b0;
  endtask

  task automatic idle_cycle();
    clk1();
  endtask

  task automatic pulse_snz();
    SNZ = 1'b1;
    clk1();
    SNZ = 1'b0;
  endtask

  task automatic pulse_stop();
    STOP = 1'b1;
    clk1();
    STOP = 1'b0;
  endtask

  task automatic do_set(input logic [7:0] h, input logic [7:0] m);
    D_H = h;
    D_M = m;
    SET = 1'b1;
    clk1();
    SET = 1'b0;
  endtask

  // Drive the alarm time with second 00 and one TICK; the bench expects RING afterwards.
  task automatic ring_at(input logic [7:0] h, input logic [7:0] m, input string tag);
    Q_H = h;
    Q_M = m;
    Q_S = 8'h00;
    tick();
    Q_S = 8'h01;
    chk({tag, "_state"}, {6'd0, STATE}, 8'h01);
    chk({tag, "_buzz"}, {7'd0, BUZZ}, 8'h01);
  endtask

  // SNZ into SNOOZE, then SNOOZE_SEC ticks back to RING.
  task automatic snooze_round(input string tag);
    pulse_snz();
    chk({tag, "_snz_state"}, {6'd0, STATE}, 8'h02);
    chk({tag, "_snz_buzz"}, {7'd0, BUZZ}, 8'h00);
    for (int i = 1; i <= SNOOZE_SEC; i++) begin
      tick();
      idle_cycle();
      if (i == SNOOZE_SEC - 1) chk({tag, "_wait_state"}, {6'd0, STATE}, 8'h02);
    end
    chk({tag, "_back_state"}, {6'd0, STATE}, 8'h01);
    chk({tag, "_back_buzz"}, {7'd0, BUZZ}, 8'h01);
  endtask

  initial begin
    nCR = 1'b0; TICK = 1'b0; SET = 1'b0; ALM_EN = 1'b0; STOP = 1'b0; SNZ = 1'b0;
    Q_H = 8'h00; Q_M = 8'h00; Q_S = 8'h00; D_H = 8'h00; D_M = 8'h00;
    #2;

    // Reset values
    clk1();
    chk("rst_ah", A_H, 8'h07);
    chk("rst_am", A_M, 8'h00);
    chk("rst_state", {6'd0, STATE}, 8'h00);
    chk("rst_buzz", {7'd0, BUZZ}, 8'h00);
    chk("rst_ring", {7'd0, RING}, 8'h00);
    nCR = 1'b1;

    // Valid load, then three rejected loads
    do_set(8'h06, 8'h30);
    chk("load_ah", A_H, 8'h06);
    chk("load_am", A_M, 8'h30);
    do_set(8'h24, 8'h30);
    chk("bad_hour_ah", A_H, 8'h06);
    do_set(8'h06, 8'h5A);
    chk("bad_min_am", A_M, 8'h30);
    do_set(8'h0A, 8'h15);
    chk("bad_nib_ah", A_H, 8'h06);
    chk("bad_nib_am", A_M, 8'h30);

    // Ring for exactly RING_SEC ticks with 1,0,1,... buzzer
    ALM_EN = 1'b1;
    ring_at(8'h06, 8'h30, "ring1");
    chk("ring1_ringflag", {7'd0, RING}, 8'h01);
    idle_cycle();
    chk("hold_no_tick_buzz", {7'd0, BUZZ}, 8'h01);
    for (int i = 1; i <= RING_SEC; i++) begin
      tick();
      if (i < RING_SEC) begin
        if (i <= 4 || i == RING_SEC - 1) begin
          chk("ring_state", {6'd0, STATE}, 8'h01);
          chk("ring_buzz", {7'd0, BUZZ}, (i % 2 == 0) ? 8'h01 : 8'h00);
        end
      end else begin
        chk("ring_end_state", {6'd0, STATE}, 8'h00);
        chk("ring_end_buzz", {7'd0, BUZZ}, 8'h00);
      end
      idle_cycle();
    end

    // Three snoozes, fourth SNZ acts as STOP
    ring_at(8'h06, 8'h30, "snzA");
    for (int k = 0; k < MAX_SNOOZE; k++) snooze_round("snzA");
    pulse_snz();
    chk("snz4_state", {6'd0, STATE}, 8'h00);

    // ALM_EN low during RING
    ring_at(8'h06, 8'h30, "dis");
    ALM_EN = 1'b0;
    clk1();
    chk("disarm_state", {6'd0, STATE}, 8'h00);
    chk("disarm_buzz", {7'd0, BUZZ}, 8'h00);

    // Matching time while disarmed
    Q_S = 8'h00;
    tick();
    chk("disarmed_match_state", {6'd0, STATE}, 8'h00);
    chk("disarmed_match_ring", {7'd0, RING}, 8'h00);
    ALM_EN = 1'b1;

    // STOP and SNZ together in RING: STOP wins
    ring_at(8'h06, 8'h30, "stopsnz");
    STOP = 1'b1;
    SNZ  = 1'b1;
    clk1();
    STOP = 1'b0;
    SNZ  = 1'b0;
    chk("stop_snz_state", {6'd0, STATE}, 8'h00);

    // SET during RING loads but keeps the state
    ring_at(8'h06, 8'h30, "setring");
    do_set(8'h12, 8'h45);
    chk("set_in_ring_state", {6'd0, STATE}, 8'h01);
    chk("set_in_ring_ah", A_H, 8'h12);
    chk("set_in_ring_am", A_M, 8'h45);
    pulse_stop();
    chk("stop_state", {6'd0, STATE}, 8'h00);

    // SET on the match edge: match uses the previous alarm (12:45)
    Q_H = 8'h12; Q_M = 8'h45; Q_S = 8'h00;
    D_H = 8'h06; D_M = 8'h30;
    SET = 1'b1; TICK = 1'b1;
    clk1();
    SET = 1'b0; TICK = 1'b0; Q_S = 8'h01;
    chk("set_match_state", {6'd0, STATE}, 8'h01);
    chk("set_match_ah", A_H, 8'h06);
    pulse_stop();

    // Reset in SNOOZE after 150 ticks, then a full fresh alarm event
    ring_at(8'h06, 8'h30, "midsnz");
    pulse_snz();
    for (int i = 0; i < 150; i++) tick();
    chk("midsnz_state", {6'd0, STATE}, 8'h02);
    nCR = 1'b0;
    clk1();
    nCR = 1'b1;
    chk("midsnz_rst_state", {6'd0, STATE}, 8'h00);
    chk("midsnz_rst_ah", A_H, 8'h07);
    chk("midsnz_rst_am", A_M, 8'h00);
    for (int i = 0; i < 5; i++) tick();
    chk("post_rst_idle", {6'd0, STATE}, 8'h00);
    ring_at(8'h07, 8'h00, "fresh");
    for (int k = 0; k < MAX_SNOOZE; k++) snooze_round("fresh");
    pulse_snz();
    chk("fresh_snz4_state", {6'd0, STATE}, 8'h00);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
